// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared definitions for the parameterised register file: the INIT/RUN
// state type of the initialisation sequencer and the default parameter
// values used by every module of the block.
package reg_file_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 15;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_NUM_RD   = 2;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage : reg_file_pkg

// File: rtl/reg_file_init_seq.sv
// reg_file_init_seq
// Initialisation sequencer for the register file. After reset it walks
// idx = 0 .. NUM_REGS-1, one register per cycle. It switches to RUN on the
// same edge that writes the last register.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, restarts the walk at idx 0
//   init_we  - high while in INIT: the top writes reg[init_idx] = init_idx
//   init_idx - register currently being initialised
//   ready    - registered, high only in RUN
module reg_file_init_seq
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_idx,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e            state_r;
    state_e            state_next_s;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] idx_next_s;
    logic              ready_r;

    // Next-state and index computation for the INIT walk.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            ST_INIT: begin
                if (idx_r == LAST_IDX) begin
                    state_next_s = ST_RUN;
                    idx_next_s   = '0;
                end else begin
                    state_next_s = ST_INIT;
                    idx_next_s   = idx_r + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                state_next_s = ST_RUN;
                idx_next_s   = idx_r;
            end
            default: begin
                state_next_s = ST_INIT;
                idx_next_s   = '0;
            end
        endcase
    end

    // State, index and ready registers.
    // ready is registered from the next state, so it always equals (state == RUN).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_INIT;
            idx_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            ready_r <= (state_next_s == ST_RUN);
        end
    end

    assign init_we  = (state_r == ST_INIT);
    assign init_idx = idx_r;
    assign ready    = ready_r;

endmodule : reg_file_init_seq

// File: rtl/reg_file_param.sv
// reg_file_param
// Parameterised register file with a pending (scoreboard) bit per register,
// NUM_RD independent combinational read ports, and write-through bypass.
// Contents are established by a self-running INIT sequence after reset,
// which loads reg[i] = i. There is no other reset of the array.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset (restarts INIT)
//   rd_addr    - NUM_RD read addresses, port k at slice k
//   rd_data    - NUM_RD read data words (combinational, 0 during INIT)
//   rd_pending - per-port pending flag of the addressed register
//   wr_en      - writeback enable
//   wr_addr    - writeback destination
//   wr_data    - writeback value
//   issue_en   - mark issue_addr pending
//   issue_addr - register to mark pending
//   ready      - high once INIT has completed
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     ready
);

    // One extra bit so that NUM_REGS == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0]   mem_r [NUM_REGS];
    logic [NUM_REGS-1:0] pending_r;

    logic                init_we_s;
    logic [ADDR_W-1:0]   init_idx_s;
    logic                ready_s;
    logic [DATA_W-1:0]   init_val_s;
    logic                init_s;
    logic                run_s;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < NUM_REGS_W);
    endfunction

    reg_file_init_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_init_seq (
        .clk      (clk),
        .rst      (rst),
        .init_we  (init_we_s),
        .init_idx (init_idx_s),
        .ready    (ready_s)
    );

    // The init value is the index, zero-extended or truncated to DATA_W.
    if (DATA_W > ADDR_W) begin : g_init_ext
        assign init_val_s = {{(DATA_W - ADDR_W){1'b0}}, init_idx_s};
    end else if (DATA_W == ADDR_W) begin : g_init_eq
        assign init_val_s = init_idx_s;
    end else begin : g_init_trunc
        assign init_val_s = init_idx_s[DATA_W-1:0];
    end

    // An edge on which rst is high never commits INIT or RUN traffic.
    assign init_s = init_we_s & ~rst;
    assign run_s  = ready_s & ~rst;

    // Array and pending update.
    // The issue is applied after the writeback, so an issue wins on a collision.
    always_ff @(posedge clk) begin
        if (init_s) begin
            mem_r[init_idx_s]     <= init_val_s;
            pending_r[init_idx_s] <= 1'b0;
        end else if (run_s) begin
            if (wr_en && in_range(wr_addr)) begin
                mem_r[wr_addr]     <= wr_data;
                pending_r[wr_addr] <= 1'b0;
            end
            if (issue_en && in_range(issue_addr)) begin
                pending_r[issue_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] data_s;
        logic              pend_s;

        assign addr_s = rd_addr[k*ADDR_W +: ADDR_W];

        // Read mux for port k: zero in INIT or out of range, otherwise bypass, otherwise array.
        always_comb begin
            data_s = '0;
            pend_s = 1'b0;
            if (!ready_s || !in_range(addr_s)) begin
                data_s = '0;
                pend_s = 1'b0;
            end else if (run_s && wr_en && (wr_addr == addr_s)) begin
                data_s = wr_data;
                pend_s = 1'b0;
            end else begin
                data_s = mem_r[addr_s];
                pend_s = pending_r[addr_s];
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data_s;
        assign rd_pending[k]               = pend_s;
    end

    assign ready = ready_s;

endmodule : reg_file_param

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param
// Directed test of reg_file_param with its default parameters. Expected read
// results are pushed to a queue as each stimulus step is driven. They are
// popped and compared against the read ports once the step has settled.
module tb_reg_file_param;

    localparam int DW = 32;
    localparam int NR = 15;
    localparam int AW = 4;
    localparam int NP = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_data;
    logic [NP-1:0]    rd_pending;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             issue_en;
    logic [AW-1:0]    issue_addr;
    logic             ready;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] data;
        logic        pend;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [NR];
    logic        model_pend [NR];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_cyc;

    reg_file_param u_dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pending (rd_pending),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int port, input int addr);
        rd_addr[port*AW +: AW] = AW'(addr);
    endtask

    task automatic push_exp(input string tag, input int port,
                            input logic [31:0] data, input logic pend);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.data = data;
        e.pend = pend;
        sb.push_back(e);
    endtask

    // Let the combinational read paths settle, then drain the queue.
    task automatic check_sb();
        exp_t        e;
        logic [31:0] obs_d;
        logic        obs_p;
        #1;
        while (sb.size() > 0) begin
            e     = sb.pop_front();
            obs_d = rd_data[e.port*DW +: DW];
            obs_p = rd_pending[e.port];
            n_assert++;
            assert (obs_d === e.data) else begin
                n_fail++;
                $error("FAIL %s data port%0d: observed %h expected %h", e.tag, e.port, obs_d, e.data);
            end
            n_assert++;
            assert (obs_p === e.pend) else begin
                n_fail++;
                $error("FAIL %s pending port%0d: observed %b expected %b", e.tag, e.port, obs_p, e.pend);
            end
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reset the reference model to the post-INIT contents.
    task automatic model_init();
        for (int r = 0; r < NR; r++) begin
            model_mem[r]  = 32'(r);
            model_pend[r] = 1'b0;
        end
    endtask

    // Count cycles until ready rises, with a fixed budget.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    // Read every register through port 0 while port 1 sits out of range.
    task automatic check_all(input string tag);
        for (int r = 0; r < NR; r++) begin
            set_rd(0, r);
            set_rd(1, 15);
            push_exp(tag, 0, model_mem[r], model_pend[r]);
            push_exp({tag, "_oob"}, 1, 32'h0000_0000, 1'b0);
            check_sb();
        end
    endtask

    initial begin
        rst        = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = 4'd0;
        wr_data    = 32'h0000_0000;
        issue_en   = 1'b0;
        issue_addr = 4'd0;

        // Reset pulse, then check the INIT-phase outputs.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("ready_after_rst", int'(ready), 0);
        set_rd(0, 0);
        set_rd(1, 9);
        push_exp("init_rd", 0, 32'h0000_0000, 1'b0);
        push_exp("init_rd", 1, 32'h0000_0000, 1'b0);
        check_sb();

        // ready rises exactly NUM_REGS cycles after the reset edge.
        wait_ready(n_cyc);
        check_val("init_latency", n_cyc, NR);
        model_init();
        for (int r = 0; r < NR; r++) begin
            set_rd(0, r);
            set_rd(1, NR - 1 - r);
            push_exp("init_val", 0, 32'(r), 1'b0);
            push_exp("init_val", 1, 32'(NR - 1 - r), 1'b0);
            check_sb();
        end

        // Write-through bypass on reg 3, then a plain read of the stored value.
        tick();
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_data = 32'hDEAD_BEEF;
        set_rd(0, 3);
        set_rd(1, 4);
        push_exp("bypass", 0, 32'hDEAD_BEEF, 1'b0);
        push_exp("bypass_other", 1, 32'h0000_0004, 1'b0);
        check_sb();
        model_mem[3] = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        push_exp("bypass_stored", 0, 32'hDEAD_BEEF, 1'b0);
        check_sb();

        // Issue reg 5: pending is visible only after the edge, on both ports.
        issue_en   = 1'b1;
        issue_addr = 4'd5;
        set_rd(0, 5);
        set_rd(1, 5);
        push_exp("issue_same_cycle", 0, 32'h0000_0005, 1'b0);
        check_sb();
        model_pend[5] = 1'b1;
        tick();
        issue_en = 1'b0;
        push_exp("issue_pending", 0, 32'h0000_0005, 1'b1);
        push_exp("issue_pending", 1, 32'h0000_0005, 1'b1);
        check_sb();

        // Writeback of reg 5 clears pending through the bypass and afterwards.
        tick();
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 32'hA5A5_0005;
        push_exp("wb_bypass", 0, 32'hA5A5_0005, 1'b0);
        push_exp("wb_bypass", 1, 32'hA5A5_0005, 1'b0);
        check_sb();
        model_mem[5]  = 32'hA5A5_0005;
        model_pend[5] = 1'b0;
        tick();
        wr_en = 1'b0;
        push_exp("wb_after", 0, 32'hA5A5_0005, 1'b0);
        check_sb();

        // Issue and writeback to reg 7 on the same edge: the issue wins.
        tick();
        wr_en      = 1'b1;
        wr_addr    = 4'd7;
        wr_data    = 32'h7777_0007;
        issue_en   = 1'b1;
        issue_addr = 4'd7;
        set_rd(0, 7);
        set_rd(1, 6);
        push_exp("collide_bypass", 0, 32'h7777_0007, 1'b0);
        push_exp("collide_other", 1, 32'h0000_0006, 1'b0);
        check_sb();
        model_mem[7]  = 32'h7777_0007;
        model_pend[7] = 1'b1;
        tick();
        wr_en    = 1'b0;
        issue_en = 1'b0;
        push_exp("collide_after", 0, 32'h7777_0007, 1'b1);
        check_sb();

        // Out-of-range write and issue to address 15 are dropped.
        tick();
        wr_en      = 1'b1;
        wr_addr    = 4'd15;
        wr_data    = 32'h0000_1234;
        issue_en   = 1'b1;
        issue_addr = 4'd15;
        set_rd(0, 15);
        set_rd(1, 15);
        push_exp("oob_bypass", 0, 32'h0000_0000, 1'b0);
        push_exp("oob_bypass", 1, 32'h0000_0000, 1'b0);
        check_sb();
        tick();
        wr_en    = 1'b0;
        issue_en = 1'b0;
        check_all("oob_array");

        // Reset again, drive traffic during INIT, and re-reset at idx 6.
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        wr_en      = 1'b1;
        wr_addr    = 4'd2;
        wr_data    = 32'hBAD0_0002;
        issue_en   = 1'b1;
        issue_addr = 4'd10;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check_val("ready_mid_init", int'(ready), 0);
        set_rd(0, 2);
        set_rd(1, 3);
        push_exp("mid_init_rd", 0, 32'h0000_0000, 1'b0);
        push_exp("mid_init_rd", 1, 32'h0000_0000, 1'b0);
        check_sb();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(n_cyc);
        wr_en    = 1'b0;
        issue_en = 1'b0;
        check_val("reinit_latency", n_cyc, NR);
        model_init();
        check_all("reinit_array");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_reg_file_param

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL expose the parameter DATA_W, default 32, meaning the register width in bits.
REQ-002 The block SHALL expose the parameter NUM_REGS, default 15, meaning the register count (2..2**ADDR_W).
REQ-003 The block SHALL expose the parameter ADDR_W, default 4, meaning the register address width.
REQ-004 The block SHALL expose the parameter NUM_RD, default 2, meaning the number of independent read ports.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port rd_addr, input, NUM_RD*ADDR_W bits: read addresses, port k at slice k.
REQ-008 The block SHALL have port rd_data, output, NUM_RD*DATA_W bits: read data, combinational.
REQ-009 The block SHALL have port rd_pending, output, NUM_RD bits: the addressed register awaits writeback.
REQ-010 The block SHALL have port wr_en, input, 1 bit: writeback enable.
REQ-011 The block SHALL have port wr_addr, input, ADDR_W bits: writeback destination.
REQ-012 The block SHALL have port wr_data, input, DATA_W bits: writeback value.
REQ-013 The block SHALL have port issue_en, input, 1 bit: mark a register pending (an in-flight producer).
REQ-014 The block SHALL have port issue_addr, input, ADDR_W bits: register to mark pending.
REQ-015 The block SHALL have port ready, output, 1 bit: initialisation complete; the block accepts traffic.

Function
REQ-016 The block SHALL use a two-state FSM: INIT and RUN.
REQ-017 In INIT, the block SHALL, each cycle, write reg[idx] = idx (zero-extended or truncated to DATA_W), clear pending[idx], and increment idx.
REQ-018 When idx == NUM_REGS-1 in INIT, the block SHALL write that last register and move to RUN on the same edge.
REQ-019 The ready output SHALL be 1 only in RUN, first asserting exactly NUM_REGS cycles after the cycle in which rst is sampled high.
REQ-020 In INIT, the block SHALL ignore wr_en and issue_en, drive rd_data to 0, and drive rd_pending to 0.
REQ-021 In RUN, when wr_en=1 and wr_addr < NUM_REGS, the block SHALL update reg[wr_addr] with wr_data and clear pending[wr_addr] at the edge.
REQ-022 In RUN, when issue_en=1 and issue_addr < NUM_REGS, the block SHALL set pending[issue_addr] at the edge.
REQ-023 When an issue and a writeback target the same register in the same cycle, pending SHALL end set (the issue wins) and the data SHALL be written.
REQ-024 On each read port in RUN, when wr_en=1 and wr_addr == rd_addr[k] (in range), rd_data[k] SHALL equal wr_data and rd_pending[k] SHALL be 0 in the same cycle (write-through bypass).
REQ-025 Otherwise, rd_data[k] SHALL equal reg[rd_addr[k]] and rd_pending[k] SHALL equal pending[rd_addr[k]].
REQ-026 Any out-of-range address (>= NUM_REGS) SHALL read data 0 and pending 0; writes or issues to such an address SHALL be dropped with no side effect.
REQ-027 Read ports SHALL be fully independent; any ports may address the same register at once.

Reset
REQ-028 While rst=1 at an edge, the block SHALL enter INIT with idx=0, and ready SHALL be 0 from the next cycle.
REQ-029 Asserting rst during RUN or mid-INIT SHALL restart the sequence from idx=0; partially initialised contents are not guaranteed until ready rises.
REQ-030 The register array SHALL have no reset other than via the INIT sequence; pending SHALL be cleared only by INIT or by writeback.

Structure
REQ-031 The shared package reg_file_pkg SHALL hold the FSM state type (INIT, RUN) and the default parameter constants.
REQ-032 The INIT counter and FSM SHALL be placed in one sub-module, reg_file_init_seq (outputs: init_we, init_idx, ready).

Verification
REQ-033 Init timing: with defaults, pulse rst for 1 cycle -> ready rises after 15 cycles, and reg[r] reads r for r = 0..14.
REQ-034 Bypass: in RUN, wr_en=1, wr_addr=3, wr_data=0xDEADBEEF, with rd_addr port0=3 -> rd_data port0 = 0xDEADBEEF in the same cycle, and reads it again on the next cycle with wr_en=0.
REQ-035 Scoreboard: issue reg 5 -> rd_pending=1 on the next cycle; writeback reg 5 -> pending=0 the same cycle (bypass) and afterwards.
REQ-036 Collision: issue_en and wr_en both on reg 7 in the same cycle -> pending[7]=1 and reg[7]=wr_data afterwards.
REQ-037 Bounds: with NUM_REGS=15, write to address 15 with 0x1234 -> no register changes, and reading address 15 returns 0 with pending 0.
REQ-038 Reset mid-init: assert rst at idx=6 -> ready rises 15 cycles after the reset, and a wr_en applied during INIT does not land.
